// File: rtl/shift_pipe_if.sv
// Issue/result handshake bundle for shift_pipe; master is the issuing side.
interface shift_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL unit, one stage per shamt bit (latency SHAMT_W cycles).
// Bubbles collapse; in_ready ripples combinationally from out_ready when the tail is full.
module shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input logic        clock,
  input logic        reset,
  shift_pipe_if.slave bus
);
  localparam int N = SHAMT_W;

  logic [N-1:0]                   vld_q, nxt_vld, ld;
  logic [N-1:0][WIDTH-1:0]        dat_q, nxt_dat;
  logic [N-1:0][SHAMT_W-1:0]      sh_q, nxt_sh;
  logic [N-1:0][1:0]              mode_q, nxt_mode;
  logic [N-1:0][TAG_W-1:0]        tag_q, nxt_tag;
  logic [WIDTH-1:0]               src_dat;

  function automatic int prev(input int k);
    return (k == 0) ? 0 : k - 1;
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic [1:0] m,
                                            input int unsigned amt);
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> amt);
    case (m)
      2'b00:   step = d << amt;
      2'b01:   step = d >> amt;
      2'b10:   step = (d >> amt) | (d[WIDTH-1] ? fill : '0);
      default: step = (d << amt) | (d >> (WIDTH - amt));
    endcase
  endfunction

  // A stage may load unless it and every stage after it are full and the output stalls.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    ld        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      full_tail = full_tail & vld_q[k];
      ld[k]     = !full_tail | bus.out_ready;
    end
  end

  always_comb begin
    nxt_vld  = '0;
    nxt_dat  = '0;
    nxt_sh   = '0;
    nxt_mode = '0;
    nxt_tag  = '0;
    src_dat  = '0;
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        nxt_vld[k]  = bus.in_valid;
        src_dat     = bus.in_data;
        nxt_sh[k]   = bus.in_shamt;
        nxt_mode[k] = bus.in_mode;
        nxt_tag[k]  = bus.in_tag;
      end else begin
        nxt_vld[k]  = vld_q[prev(k)];
        src_dat     = dat_q[prev(k)];
        nxt_sh[k]   = sh_q[prev(k)];
        nxt_mode[k] = mode_q[prev(k)];
        nxt_tag[k]  = tag_q[prev(k)];
      end
      nxt_dat[k] = nxt_sh[k][k] ? step(src_dat, nxt_mode[k], 32'd1 << k) : src_dat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      dat_q  <= '0;
      sh_q   <= '0;
      mode_q <= '0;
      tag_q  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (ld[k]) begin
          vld_q[k]  <= nxt_vld[k];
          dat_q[k]  <= nxt_dat[k];
          sh_q[k]   <= nxt_sh[k];
          mode_q[k] <= nxt_mode[k];
          tag_q[k]  <= nxt_tag[k];
        end
      end
    end
  end

  // The last stage's shamt/mode are kept so every stage looks alike; nothing reads them.
  logic unused_last;
  assign unused_last = ^{sh_q[N-1], mode_q[N-1]};

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld_q[N-1];
  assign bus.out_data  = dat_q[N-1];
  assign bus.out_tag   = tag_q[N-1];
endmodule
